// File: rtl/bcd_wave_gen.sv
`default_nettype none
// bcd_wave_gen: converts a six-digit BCD frequency into a DDS tuning word and
// emits an 8-bit sawtooth / square / triangle / inverse-sawtooth sample stream.
module bcd_wave_gen #(
  parameter int          PHASE_W = 32,
  parameter int unsigned K_SCALE = 720575940
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic [3:0]  fre_num_u,
  input  logic [3:0]  fre_num_d,
  input  logic [3:0]  fre_num_h,
  input  logic [3:0]  fre_num_t,
  input  logic [3:0]  fre_num_m,
  input  logic [3:0]  fre_num_l,
  input  logic        load,
  input  logic [1:0]  wave_sel,
  output logic        busy,
  output logic [19:0] fre_bin,
  output logic [7:0]  data_out,
  output logic        sync
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_MULT  = 2'd2;
  localparam logic [1:0] S_APPLY = 2'd3;

  localparam logic [29:0] K_W = 30'(K_SCALE);

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [23:0]        digits;
  logic [19:0]        acc;
  logic [49:0]        prod;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw;
  logic               wrap;
  logic [3:0]         cur_digit;
  logic [3:0]         dig_val;
  logic [PHASE_W:0]   phase_sum;
  logic [7:0]         p;

  always_comb begin
    case (idx)
      3'd0:    cur_digit = digits[3:0];
      3'd1:    cur_digit = digits[7:4];
      3'd2:    cur_digit = digits[11:8];
      3'd3:    cur_digit = digits[15:12];
      3'd4:    cur_digit = digits[19:16];
      3'd5:    cur_digit = digits[23:20];
      default: cur_digit = 4'd0;
    endcase
    // Non-BCD codes contribute nothing to the sum.
    dig_val = (cur_digit > 4'd9) ? 4'd0 : cur_digit;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      digits  <= 24'd0;
      acc     <= 20'd0;
      prod    <= 50'd0;
      fre_bin <= 20'd0;
      ftw     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            digits <= {fre_num_l, fre_num_m, fre_num_t, fre_num_h, fre_num_d, fre_num_u};
            acc    <= 20'd0;
            idx    <= 3'd5;
            busy   <= 1'b1;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          acc <= (acc << 3) + (acc << 1) + {16'd0, dig_val};
          if (idx == 3'd0) begin
            state <= S_MULT;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        S_MULT: begin
          prod    <= 50'(acc) * 50'(K_W);
          fre_bin <= acc;
          state   <= S_APPLY;
        end
        S_APPLY: begin
          ftw   <= PHASE_W'(prod[49:24]);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign phase_sum = {1'b0, phase} + {1'b0, ftw};
  assign p         = phase[PHASE_W-1 -: 8];

  // wrap marks the carry; sync is delayed once more to line up with data_out.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      wrap     <= 1'b0;
      sync     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      phase <= phase_sum[PHASE_W-1:0];
      wrap  <= phase_sum[PHASE_W];
      sync  <= wrap;
      case (wave_sel)
        2'b00:   data_out <= p;
        2'b01:   data_out <= p[7] ? 8'hFF : 8'h00;
        2'b10:   data_out <= p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
        default: data_out <= ~p;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_wave_gen.sv
`default_nettype none
// tb_bcd_wave_gen: directed loads with hand-computed fre_bin/ftw values; a cycle
// model queues expected outputs that a monitor pops and compares on each negedge.
module tb_bcd_wave_gen;

  logic        clk100   = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [23:0] digs     = 24'd0;
  logic [1:0]  wave_sel = 2'b00;
  logic        busy;
  logic        sync;
  logic [19:0] fre_bin;
  logic [7:0]  data_out;

  always #5 clk100 = ~clk100;

  bcd_wave_gen dut (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .fre_num_u (digs[3:0]),
    .fre_num_d (digs[7:4]),
    .fre_num_h (digs[11:8]),
    .fre_num_t (digs[15:12]),
    .fre_num_m (digs[19:16]),
    .fre_num_l (digs[23:20]),
    .load      (load),
    .wave_sel  (wave_sel),
    .busy      (busy),
    .fre_bin   (fre_bin),
    .data_out  (data_out),
    .sync      (sync)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        b;
    logic [19:0] fb;
    logic [7:0]  d;
    logic        s;
  } exp_t;

  exp_t q[$];

  // Hand-computed expectations for the load currently being issued.
  logic [19:0] exp_fb  = 20'd0;
  logic [31:0] exp_ftw = 32'd0;

  logic [31:0] m_phase, m_ftw, pend_ftw;
  logic [19:0] m_fb, pend_fb;
  logic        m_busy, m_wrap;
  int          m_cnt;
  logic [32:0] m_sum;

  assign m_sum = {1'b0, m_phase} + {1'b0, m_ftw};

  function automatic logic [7:0] shape(input logic [1:0] sel, input logic [7:0] ph);
    case (sel)
      2'b00:   return ph;
      2'b01:   return ph[7] ? 8'hFF : 8'h00;
      2'b10:   return ph[7] ? ~{ph[6:0], 1'b0} : {ph[6:0], 1'b0};
      default: return ~ph;
    endcase
  endfunction

  function automatic exp_t mk(input logic b, input logic [19:0] fb, input logic [7:0] d, input logic s);
    exp_t e;
    e.b  = b;
    e.fb = fb;
    e.d  = d;
    e.s  = s;
    return e;
  endfunction

  always @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 32'd0;
      m_ftw    <= 32'd0;
      m_fb     <= 20'd0;
      m_busy   <= 1'b0;
      m_wrap   <= 1'b0;
      m_cnt    <= 0;
      pend_fb  <= 20'd0;
      pend_ftw <= 32'd0;
      q.delete();
    end else begin
      q.push_back(mk(m_busy ? (m_cnt != 1) : load,
                     (m_busy && m_cnt == 2) ? pend_fb : m_fb,
                     shape(wave_sel, m_phase[31:24]),
                     m_wrap));
      m_phase <= m_sum[31:0];
      m_wrap  <= m_sum[32];
      if (!m_busy) begin
        if (load) begin
          m_busy   <= 1'b1;
          m_cnt    <= 8;
          pend_fb  <= exp_fb;
          pend_ftw <= exp_ftw;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 2) m_fb <= pend_fb;
        if (m_cnt == 1) begin
          m_ftw  <= pend_ftw;
          m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk100) begin : monitor
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("busy", 32'(busy), 32'(e.b));
      check("fre_bin", 32'(fre_bin), 32'(e.fb));
      check("data_out", 32'(data_out), 32'(e.d));
      check("sync", 32'(sync), 32'(e.s));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic do_load(input logic [23:0] d, input logic [19:0] fb, input logic [31:0] ftw);
    digs    = d;
    exp_fb  = fb;
    exp_ftw = ftw;
    load    = 1'b1;
    cycles(1);
    load    = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int nsync;
    int t [3];
    int hi;
    int maxv;
    int minv;
    int changes;
    logic [7:0] d0;

    @(negedge clk100);
    @(negedge clk100);
    #2 rst_n = 1'b1;
    cycles(1);

    // Reset mid-run and mid-conversion.
    do_load(24'h100000, 20'd100000, 32'd4294967);
    cycles(300);
    do_load(24'h000042, 20'd42, 32'd1803);
    cycles(3);
    @(negedge clk100);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fre_bin", 32'(fre_bin), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    @(negedge clk100);
    #2 rst_n = 1'b1;
    cycles(100);

    // 42 Hz: busy exactly 8 cycles, ftw 1803.
    do_load(24'h000042, 20'd42, 32'd1803);
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (busy) n_busy++;
    end
    check("busy_len", 32'(n_busy), 32'd8);
    check("fre_bin_42", 32'(fre_bin), 32'd42);
    cycles(50);

    // Square at 100 kHz: ftw 4294967, period 1000 or 1001 cycles.
    wave_sel = 2'b01;
    do_load(24'h100000, 20'd100000, 32'd4294967);
    nsync = 0;
    hi    = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk100);
      if (nsync == 1 && data_out == 8'hFF) hi++;
      if (sync) begin
        if (nsync < 3) t[nsync] = i;
        nsync++;
      end
    end
    check("sync_count_ge3", 32'(nsync >= 3), 32'd1);
    if (nsync >= 3) begin
      check("sync_gap0", 32'((t[1] - t[0]) == 1000 || (t[1] - t[0]) == 1001), 32'd1);
      check("sync_gap1", 32'((t[2] - t[1]) == 1000 || (t[2] - t[1]) == 1001), 32'd1);
      check("square_duty", 32'(hi >= 495 && hi <= 505), 32'd1);
    end
    cycles(1);

    // Triangle at 390625 Hz: ftw 16777215, p steps ~1 per cycle.
    wave_sel = 2'b10;
    do_load(24'h390625, 20'd390625, 32'd16777215);
    cycles(20);
    maxv = 0;
    minv = 255;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk100);
      if (int'(data_out) > maxv) maxv = int'(data_out);
      if (int'(data_out) < minv) minv = int'(data_out);
    end
    check("tri_max", 32'(maxv), 32'd255);
    check("tri_min", 32'(minv), 32'd0);
    cycles(1);

    // Busy: second load 3 cycles later is dropped; then invalid units digit.
    wave_sel = 2'b00;
    do_load(24'h000123, 20'd123, 32'd5282);
    cycles(2);
    do_load(24'h000999, 20'd999, 32'd0);
    cycles(12);
    check("busy_ignore_fre_bin", 32'(fre_bin), 32'd123);
    do_load(24'h00005C, 20'd50, 32'd2147);
    cycles(12);
    check("invalid_digit_fre_bin", 32'(fre_bin), 32'd50);

    // Phase continuity 1000 -> 2000 Hz, then zero freezes output.
    wave_sel = 2'b11;
    do_load(24'h001000, 20'd1000, 32'd42949);
    cycles(2000);
    do_load(24'h002000, 20'd2000, 32'd85899);
    cycles(500);
    wave_sel = 2'b00;
    do_load(24'h100000, 20'd100000, 32'd4294967);
    cycles(300);
    do_load(24'h000000, 20'd0, 32'd0);
    cycles(12);
    @(negedge clk100);
    d0      = data_out;
    changes = 0;
    nsync   = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk100);
      if (data_out != d0) changes++;
      if (sync) nsync++;
    end
    check("zero_frozen_changes", 32'(changes), 32'd0);
    check("zero_sync_count", 32'(nsync), 32'd0);

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
